multicycle_control: RTL and testbench

- Upstream control FSM for the multicycle datapath.
- Consumes the decoded opcode and branch-condition result from the datapath.
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives every datapath control input: SelectIns, RegWrite, RegDst, ALUSrcA, ALUSrcB, MemWrite, MemtoReg, BEQ, PCSrc, plus PC/IR write enables.

---
 rtl/multicycle_control.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM sequencing fetch/decode/execute/memory/
// writeback for the multicycle datapath and driving all its control inputs.
//
// Parameters:
//   HALT_OPCODE  - opcode that parks the FSM in HALT (default 6'b111111)
//   ILLEGAL_HALT - 1: illegal opcodes go to HALT; 0: treated as NOP
// Ports:
//   clk, rst_n (async, active-low), opcode[5:0], branch, stall
//   SelectIns, RegWrite, RegDst, ALUSrcA, ALUSrcB[1:0], MemWrite,
//   MemtoReg, BEQ, PCSrc[1:0], pc_write, ir_write, illegal, halted
// Optional build macro MULTICYCLE_CONTROL_PERF_EN adds the
//   retired[31:0] and cycles[31:0] performance counters.

module multicycle_control #(
    parameter logic [5:0] HALT_OPCODE  = 6'b111111,
    parameter bit         ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       branch,
    input  logic       stall,
    output logic       SelectIns,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       BEQ,
    output logic [1:0] PCSrc,
    output logic       pc_write,
    output logic       ir_write,
    output logic       illegal,
    output logic       halted
`ifdef MULTICYCLE_CONTROL_PERF_EN
    ,
    output logic [31:0] retired,
    output logic [31:0] cycles
`endif
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_ALU = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_MEM = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;

    // Remembered from DECODE: R-type vs I-type for WB_ALU, and the
    // branch sense for BRANCH, so later opcode changes are ignored.
    logic r_rtype;
    logic r_bne;

    logic w_is_halt;
    logic w_is_r;
    logic w_is_i;
    logic w_is_lw;
    logic w_is_sw;
    logic w_is_br;
    logic w_is_jmp;
    logic w_legal;
    logic w_take;

    // HALT_OPCODE wins over any other match so the flags stay one-hot.
    assign w_is_halt = (opcode == HALT_OPCODE);
    assign w_is_r    = !w_is_halt && (opcode[5:4] == 2'b00);
    assign w_is_i    = !w_is_halt && (opcode[5:4] == 2'b01);
    assign w_is_lw   = !w_is_halt && (opcode == 6'b100000);
    assign w_is_sw   = !w_is_halt && (opcode == 6'b100001);
    assign w_is_br   = !w_is_halt && (opcode[5:1] == 5'b10001);
    assign w_is_jmp  = !w_is_halt && (opcode == 6'b100100);
    assign w_legal   = w_is_halt | w_is_r | w_is_i | w_is_lw
                     | w_is_sw | w_is_br | w_is_jmp;

    // A DECODE cycle that actually dispatches.
    assign w_take = (r_state == S_DECODE) && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rtype <= 1'b0;
            r_bne   <= 1'b0;
        end else if (w_take) begin
            r_rtype <= w_is_r;
            r_bne   <= opcode[0];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT: w_next = S_FETCH;
            S_HALT: w_next = S_HALT;
            S_FETCH: if (!stall) w_next = S_DECODE;
            S_DECODE: begin
                if (!stall) begin
                    unique case (1'b1)
                        w_is_halt: w_next = S_HALT;
                        w_is_r:    w_next = S_EXEC_R;
                        w_is_i:    w_next = S_EXEC_I;
                        w_is_lw:   w_next = S_MEM_RD;
                        w_is_sw:   w_next = S_MEM_WR;
                        w_is_br:   w_next = S_BRANCH;
                        w_is_jmp:  w_next = S_JUMP;
                        default:   w_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    endcase
                end
            end
            S_EXEC_R, S_EXEC_I: if (!stall) w_next = S_WB_ALU;
            S_MEM_RD:           if (!stall) w_next = S_WB_MEM;
            S_WB_ALU, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP: begin
                if (!stall) w_next = S_FETCH;
            end
            default: w_next = S_INIT;
        endcase
    end

    always_comb begin
        SelectIns = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'd0;
        MemWrite  = 1'b0;
        MemtoReg  = 1'b0;
        BEQ       = 1'b0;
        PCSrc     = 2'd0;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        illegal   = 1'b0;
        halted    = 1'b0;
        case (r_state)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: illegal = !stall && !w_legal;
            S_EXEC_R: ALUSrcA = 1'b1;
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                RegDst   = r_rtype;
                ALUSrcA  = 1'b1;
                ALUSrcB  = r_rtype ? 2'd0 : 2'd2;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: MemWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                BEQ      = r_bne;
                PCSrc    = 2'd2;
                pc_write = branch;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                PCSrc    = 2'd2;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
        // INIT and HALT carry no enables, so masking there is harmless.
        if (stall) begin
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            pc_write = 1'b0;
            ir_write = 1'b0;
        end
    end

`ifdef MULTICYCLE_CONTROL_PERF_EN
    logic [31:0] r_retired;
    logic [31:0] r_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= 32'd0;
            r_cycles  <= 32'd0;
        end else begin
            if (r_state != S_INIT) begin
                r_cycles <= r_cycles + 32'd1;
            end
            // Any entry into FETCH other than the first one after INIT
            // closes out an instruction.
            if (w_next == S_FETCH && r_state != S_INIT
                && r_state != S_FETCH) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign retired = r_retired;
    assign cycles  = r_cycles;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized scoreboard bench for multicycle_control.
// The driver builds per-instruction step lists and queues expectations.

module tb_multicycle_control;

    localparam logic [5:0] HALT_OP = 6'b111111;

    typedef struct packed {
        logic       sel;
        logic       rw;
        logic       rd;
        logic       asa;
        logic [1:0] asb;
        logic       mw;
        logic       m2r;
        logic       beq;
        logic [1:0] pcs;
        logic       pcw;
        logic       irw;
        logic       ill;
        logic       hlt;
    } ctl_t;

    typedef struct packed {
        ctl_t        c;
        logic        h2;
        logic [31:0] ret;
        logic [31:0] cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       branch = 1'b0;
    logic       stall = 1'b0;

    logic       SelectIns, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       MemWrite, MemtoReg, BEQ;
    logic [1:0] PCSrc;
    logic       pc_write, ir_write, illegal, halted;

    logic       h_sel, h_rw, h_rd, h_asa;
    logic [1:0] h_asb;
    logic       h_mw, h_m2r, h_beq;
    logic [1:0] h_pcs;
    logic       h_pcw, h_irw, h_ill, h_halted;
`ifdef MULTICYCLE_CONTROL_PERF_EN
    logic [31:0] retired, cycles, h_ret, h_cyc;
`endif

    always #5 clk = ~clk;

    multicycle_control #(.HALT_OPCODE(HALT_OP), .ILLEGAL_HALT(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .branch(branch), .stall(stall),
        .SelectIns(SelectIns), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .BEQ(BEQ), .PCSrc(PCSrc),
        .pc_write(pc_write), .ir_write(ir_write),
        .illegal(illegal), .halted(halted)
`ifdef MULTICYCLE_CONTROL_PERF_EN
        , .retired(retired), .cycles(cycles)
`endif
    );

    multicycle_control #(.HALT_OPCODE(HALT_OP), .ILLEGAL_HALT(1'b1)) u_dut_h (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .branch(branch), .stall(stall),
        .SelectIns(h_sel), .RegWrite(h_rw), .RegDst(h_rd),
        .ALUSrcA(h_asa), .ALUSrcB(h_asb), .MemWrite(h_mw),
        .MemtoReg(h_m2r), .BEQ(h_beq), .PCSrc(h_pcs),
        .pc_write(h_pcw), .ir_write(h_irw),
        .illegal(h_ill), .halted(h_halted)
`ifdef MULTICYCLE_CONTROL_PERF_EN
        , .retired(h_ret), .cycles(h_cyc)
`endif
    );

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_cyc = 0;
    logic        exp_h2 = 1'b0;
    logic [31:0] exp_ret = 32'd0;
    logic [31:0] exp_cyc = 32'd0;

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        ctl_t got;
        n_cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            got = {SelectIns, RegWrite, RegDst, ALUSrcA, ALUSrcB,
                   MemWrite, MemtoReg, BEQ, PCSrc, pc_write,
                   ir_write, illegal, halted};
            n_chk++;
            if (got !== e.c) begin
                n_fail++;
                $display("FAIL ctl cyc=%0d got=%h exp=%h",
                         n_cyc, got, e.c);
            end
            n_chk++;
            if (h_halted !== e.h2) begin
                n_fail++;
                $display("FAIL halt_on_illegal cyc=%0d got=%b exp=%b",
                         n_cyc, h_halted, e.h2);
            end
`ifdef MULTICYCLE_CONTROL_PERF_EN
            n_chk++;
            if (retired !== e.ret || cycles !== e.cyc) begin
                n_fail++;
                $display("FAIL perf cyc=%0d got=%0d/%0d exp=%0d/%0d",
                         n_cyc, retired, cycles, e.ret, e.cyc);
            end
`endif
        end
    end

    function automatic bit is_ill(input logic [5:0] op);
        return !(op[5:4] == 2'b00 || op[5:4] == 2'b01 ||
                 (op >= 6'd32 && op <= 6'd36) || op == HALT_OP);
    endfunction

    function automatic ctl_t stall_mask(input ctl_t c);
        ctl_t m = c;
        m.rw  = 1'b0;
        m.mw  = 1'b0;
        m.pcw = 1'b0;
        m.irw = 1'b0;
        m.ill = 1'b0;
        return m;
    endfunction

    // One clock of stimulus; pushes what the DUT must show this cycle.
    task automatic tick(input ctl_t c, input bit stl, input bit br,
                        input logic [5:0] op, input bit init,
                        input bit rstv);
        exp_t e;
        @(posedge clk);
        #1;
        stall  = stl;
        branch = br;
        opcode = op;
        rst_n  = rstv;
        if (!rstv) begin
            exp_ret = 32'd0;
            exp_cyc = 32'd0;
            exp_h2  = 1'b0;
            c = '0;
        end
        e.c   = c;
        e.h2  = exp_h2;
        e.ret = exp_ret;
        e.cyc = exp_cyc;
        q.push_back(e);
        if (!init && rstv) exp_cyc = exp_cyc + 32'd1;
    endtask

    task automatic do_reset();
        ctl_t z = '0;
        tick(z, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        tick(z, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        tick(z, 1'($urandom % 2), 1'b0, 6'd0, 1'b1, 1'b1);
    endtask

    // Builds the instruction's step list from the opcode map, then plays
    // it with optional random/forced stalls. brm<0 randomizes branch.
    task automatic do_instr(input logic [5:0] op, input bit rs,
                            input int fs_step, input int fs_n,
                            input int brm, input bit abort);
        ctl_t st[$];
        ctl_t c;
        int   bd = -1;
        int   n;
        bit   br;
        bit   hlt = (op == HALT_OP);
        bit   ill = is_ill(op);
        logic [5:0] od;
        c = '0; c.irw = 1'b1; c.pcw = 1'b1; st.push_back(c);
        c = '0; c.ill = ill; st.push_back(c);
        if (!hlt && !ill) begin
            if (op[5:4] == 2'b00) begin
                c = '0; c.asa = 1'b1; st.push_back(c);
                c.rw = 1'b1; c.rd = 1'b1; st.push_back(c);
            end else if (op[5:4] == 2'b01) begin
                c = '0; c.asa = 1'b1; c.asb = 2'd2; st.push_back(c);
                c.rw = 1'b1; st.push_back(c);
            end else if (op == 6'd32) begin
                c = '0; st.push_back(c);
                c.rw = 1'b1; c.m2r = 1'b1; st.push_back(c);
            end else if (op == 6'd33) begin
                c = '0; c.mw = 1'b1; st.push_back(c);
            end else if (op == 6'd34 || op == 6'd35) begin
                c = '0; c.asa = 1'b1; c.beq = op[0]; c.pcs = 2'd2;
                bd = st.size();
                st.push_back(c);
            end else begin
                c = '0; c.pcw = 1'b1; c.pcs = 2'd2; st.push_back(c);
            end
        end
        foreach (st[i]) begin
            if (i == fs_step) n = fs_n;
            else if (rs && $urandom_range(0, 3) == 0) n = $urandom_range(1, 3);
            else n = 0;
            for (int k = 0; k < n; k++) begin
                br = (brm < 0) ? 1'($urandom % 2) : 1'(brm);
                od = (i == 1) ? op : 6'($urandom);
                tick(stall_mask(st[i]), 1'b1, br, od, 1'b0, 1'b1);
            end
            br = (brm < 0) ? 1'($urandom % 2) : 1'(brm);
            od = (i == 1) ? op : 6'($urandom);
            c = st[i];
            if (i == bd) c.pcw = br;
            if (abort && i == st.size() - 1) begin
                tick(c, 1'b0, br, od, 1'b1, 1'b0);
                return;
            end
            tick(c, 1'b0, br, od, 1'b0, 1'b1);
            if (i == 1 && (hlt || ill)) exp_h2 = 1'b1;
        end
        if (!hlt) exp_ret = exp_ret + 32'd1;
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] op;
        int k = $urandom_range(0, 7);
        case (k)
            0: op = {2'b00, 4'($urandom)};
            1: op = {2'b01, 4'($urandom)};
            7: begin
                op = 6'($urandom);
                while (!is_ill(op)) op = 6'($urandom);
            end
            default: op = 6'(30 + k);
        endcase
        return op;
    endfunction

    initial begin
        ctl_t h;
        do_reset();
        do_instr(6'b000010, 0, -1, 0, -1, 0);
        do_instr(6'b100000, 0, -1, 0, -1, 0);
        do_instr(6'b100001, 0, -1, 0, -1, 0);
        do_instr(6'b011010, 0, -1, 0, -1, 0);
        do_instr(6'b100011, 0, -1, 0, 1, 0);
        do_instr(6'b100011, 0, -1, 0, 0, 0);
        do_instr(6'b100010, 0, -1, 0, 1, 0);
        do_instr(6'b100011, 0, 2, 3, 1, 0);
        do_instr(6'b100100, 0, -1, 0, -1, 0);
        do_instr(6'b110000, 0, -1, 0, -1, 0);
        do_instr(6'b000001, 0, 1, 2, -1, 0);
        do_instr(6'b110000, 0, 1, 2, -1, 0);
        for (int i = 0; i < 300; i++) begin
            do_instr(rand_op(), 1, -1, 0, -1, 0);
        end
        do_instr(6'b100000, 0, -1, 0, -1, 1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_instr(6'b000010, 0, -1, 0, -1, 0);
        end
        do_instr(HALT_OP, 0, -1, 0, -1, 0);
        h = '0;
        h.hlt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(h, 1'($urandom % 2), 1'($urandom % 2), 6'($urandom),
                 1'b0, 1'b1);
        end
        do_reset();
        do_instr(6'b010101, 1, -1, 0, -1, 0);
        repeat (3) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
